// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between adjacent pipeline stages: upstream beat in, registered beat out.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register: one main slot, optional one-entry skid slot,
// flush-to-bubble, freeze on halt/stall, and saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int                DATA_W   = 48,
  parameter int                CTRL_W   = 12,
  parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}},
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_sys,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clr,
  pipe_stage_skid_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  localparam bit               HAS_SKID = (SKID != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic              frz_s;
  logic              drain_s;
  logic              accept_s;
  logic              vq_r;
  logic              sv_r;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] sdata_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [CTRL_W-1:0] sctrl_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Handshake outputs; with a skid slot in_ready never depends on out_ready
  always_comb begin
    frz_s         = halt_sys | stall;
    drain_s       = ~vq_r | bus.out_ready;
    bus.out_valid = vq_r & ~frz_s;
    bus.out_data  = data_r;
    bus.out_ctrl  = ctrl_r;
    if (HAS_SKID) begin
      bus.in_ready = rst & ~frz_s & ~sv_r;
    end else begin
      bus.in_ready = rst & ~frz_s & drain_s;
    end
    accept_s = bus.in_valid & bus.in_ready;
  end

  // Slot state: reset, then flush (beats in flight are dropped), then freeze, then transfer
  always_ff @(posedge clk) begin
    if (!rst) begin
      vq_r    <= 1'b0;
      sv_r    <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
      sdata_r <= {DATA_W{1'b0}};
      ctrl_r  <= CTRL_NOP;
      sctrl_r <= CTRL_NOP;
    end else if (flush) begin
      vq_r   <= 1'b0;
      sv_r   <= 1'b0;
      ctrl_r <= CTRL_NOP;
    end else if (frz_s) begin
      vq_r <= vq_r;
      sv_r <= sv_r;
    end else if (drain_s) begin
      if (HAS_SKID && sv_r) begin
        data_r <= sdata_r;
        ctrl_r <= sctrl_r;
        sv_r   <= 1'b0;
      end else if (accept_s) begin
        data_r <= bus.in_data;
        ctrl_r <= bus.in_ctrl;
        vq_r   <= 1'b1;
      end else begin
        vq_r <= 1'b0;
      end
    end else if (HAS_SKID && accept_s) begin
      sdata_r <= bus.in_data;
      sctrl_r <= bus.in_ctrl;
      sv_r    <= 1'b1;
    end
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      stall_cnt  <= {CNT_W{1'b0}};
      bubble_cnt <= {CNT_W{1'b0}};
    end else begin
      if (frz_s) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (~vq_r & ~frz_s & ~flush) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed stimulus with a queue scoreboard and a negedge monitor.
module tb_pipe_stage_skid;
  localparam int DW = 48;
  localparam int CW = 12;
  localparam logic [CW-1:0] NOP = 12'h000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic halt_sys = 1'b0, stall = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
  logic [15:0] stall_cnt, bubble_cnt;
  logic c_stall = 1'b0, c_clr = 1'b0;
  logic [3:0] c_scnt, c_bcnt;
  logic [15:0] p_scnt, p_bcnt;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) bus();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) c_bus();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) p_bus();

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .stall(stall), .flush(flush),
    .cnt_clr(cnt_clr), .bus(bus), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1), .CNT_W(4)) u_cnt (
    .clk(clk), .rst(rst), .halt_sys(1'b0), .stall(c_stall), .flush(1'b0),
    .cnt_clr(c_clr), .bus(c_bus), .stall_cnt(c_scnt), .bubble_cnt(c_bcnt));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(0), .CNT_W(16)) u_plain (
    .clk(clk), .rst(rst), .halt_sys(1'b0), .stall(1'b0), .flush(1'b0),
    .cnt_clr(1'b0), .bus(p_bus), .stall_cnt(p_scnt), .bubble_cnt(p_bcnt));

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;
  logic [DW+CW-1:0] sb_q[$];
  logic [15:0] exp_scnt = 16'd0;
  logic [15:0] exp_bcnt = 16'd0;
  logic [DW-1:0] nxt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
    return d[CW-1:0] ^ 12'hA5A;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Monitor: compare handshake/counters against the model, pop on emit, push on accept
  logic m_frz, m_vq, m_ov, m_ir;
  logic [DW+CW-1:0] m_beat;
  always @(negedge clk) begin
    if (mon_en) begin
      m_frz = halt_sys | stall;
      m_vq  = (sb_q.size() > 0);
      m_ov  = m_vq & ~m_frz;
      m_ir  = rst & ~m_frz & (sb_q.size() < 2);
      chk("mon_stall_cnt", stall_cnt, exp_scnt);
      chk("mon_bubble_cnt", bubble_cnt, exp_bcnt);
      chk("mon_out_valid", bus.out_valid, m_ov);
      chk("mon_in_ready", bus.in_ready, m_ir);
      if (m_ov && bus.out_ready) begin
        m_beat = sb_q.pop_front();
        chk("sb_out_data", bus.out_data, m_beat[DW+CW-1:CW]);
        chk("sb_out_ctrl", bus.out_ctrl, m_beat[CW-1:0]);
      end
      if (m_ir && bus.in_valid && !flush) sb_q.push_back({bus.in_data, bus.in_ctrl});
      if (!rst || flush) sb_q.delete();
      if (!rst || cnt_clr) begin
        exp_scnt = 16'd0;
        exp_bcnt = 16'd0;
      end else begin
        if (m_frz) exp_scnt = sat16(exp_scnt);
        if (!m_vq && !m_frz && !flush) exp_bcnt = sat16(exp_bcnt);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One cycle of streaming: present nxt, advance it only if the stage took it
  task automatic beat(input logic ordy);
    logic acc;
    bus.out_ready = ordy;
    bus.in_valid  = 1'b1;
    bus.in_data   = nxt;
    bus.in_ctrl   = ctrl_of(nxt);
    #1 acc = bus.in_ready;
    cyc(1);
    if (acc) nxt = nxt + 48'd1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_ctrl"}, bus.out_ctrl, NOP);
    chk({tag, "_out_data"}, bus.out_data, 48'd0);
    chk({tag, "_stall_cnt"}, stall_cnt, 16'd0);
    chk({tag, "_bubble_cnt"}, bubble_cnt, 16'd0);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 48'd0; bus.in_ctrl = 12'd0; bus.out_ready = 1'b0;
    c_bus.in_valid = 1'b0; c_bus.in_data = 48'd0; c_bus.in_ctrl = 12'd0; c_bus.out_ready = 1'b1;
    p_bus.in_valid = 1'b0; p_bus.in_data = 48'd0; p_bus.in_ctrl = 12'd0; p_bus.out_ready = 1'b0;
    cyc(2);
    mon_en = 1'b1;
    cyc(1);
    rst = 1'b1;
    #1 chk_reset_state("rst_release");

    // Plain slot: in_ready follows out_ready combinationally when full
    p_bus.in_valid = 1'b1; p_bus.in_data = 48'h55; p_bus.in_ctrl = 12'h001;
    #1 chk("plain_ready_empty", p_bus.in_ready, 1'b1);
    cyc(1);
    chk("plain_valid", p_bus.out_valid, 1'b1);
    chk("plain_data", p_bus.out_data, 48'h55);
    chk("plain_ready_blocked", p_bus.in_ready, 1'b0);
    p_bus.in_data = 48'h66; p_bus.out_ready = 1'b1;
    #1 chk("plain_ready_drain", p_bus.in_ready, 1'b1);
    cyc(1);
    chk("plain_data2", p_bus.out_data, 48'h66);
    p_bus.in_valid = 1'b0;
    cyc(1);
    chk("plain_empty", p_bus.out_valid, 1'b0);

    // Streaming 1..8 at full rate, one-cycle latency
    nxt = 48'd1;
    for (int k = 1; k <= 8; k++) begin
      beat(1'b1);
      chk("stream_valid", bus.out_valid, 1'b1);
      chk("stream_data", bus.out_data, 48'(k));
    end
    bus.in_valid = 1'b0;
    cyc(2);

    // Back-pressure: skid takes exactly one beat
    nxt = 48'd16;
    beat(1'b1); beat(1'b1); beat(1'b0);
    chk("skid_full_ready", bus.in_ready, 1'b0);
    chk("skid_main_data", bus.out_data, 48'd17);
    beat(1'b0); beat(1'b0);
    chk("skid_hold_ready", bus.in_ready, 1'b0);
    chk("skid_hold_data", bus.out_data, 48'd17);
    beat(1'b1);
    chk("skid_move_data", bus.out_data, 48'd18);
    chk("skid_move_ready", bus.in_ready, 1'b1);
    beat(1'b1);
    chk("skid_resume19", bus.out_data, 48'd19);
    beat(1'b1);
    chk("skid_resume20", bus.out_data, 48'd20);
    bus.in_valid = 1'b0;
    cyc(2);

    // Stall for 4 cycles holding 0xABCD
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 48'hABCD; bus.in_ctrl = ctrl_of(48'hABCD);
    cyc(1);
    bus.in_valid = 1'b0; stall = 1'b1; bus.out_ready = 1'b1;
    repeat (4) begin
      #1 chk("stall_out_valid", bus.out_valid, 1'b0);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      cyc(1);
    end
    stall = 1'b0;
    #1 chk("stall_release_valid", bus.out_valid, 1'b1);
    chk("stall_release_data", bus.out_data, 48'hABCD);
    chk("stall_cnt_4", stall_cnt, 16'd4);
    cyc(1);

    // Flush with both slots full, under stall
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 48'h100; bus.in_ctrl = ctrl_of(48'h100);
    cyc(1);
    bus.in_data = 48'h101; bus.in_ctrl = ctrl_of(48'h101);
    cyc(1);
    chk("flush_pre_ready", bus.in_ready, 1'b0);
    bus.in_data = 48'h102; bus.in_ctrl = ctrl_of(48'h102); stall = 1'b1; flush = 1'b1;
    cyc(1);
    stall = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
    #1 chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_ctrl_nop", bus.out_ctrl, NOP);
    chk("flush_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    cyc(2);
    chk("flush_no_emit", bus.out_valid, 1'b0);

    // Flush drops a beat accepted in the same cycle
    bus.in_valid = 1'b1; bus.in_data = 48'h200; bus.in_ctrl = ctrl_of(48'h200); flush = 1'b1;
    #1 chk("flush_acc_ready", bus.in_ready, 1'b1);
    cyc(1);
    flush = 1'b0; bus.in_valid = 1'b0;
    #1 chk("flush_acc_dropped", bus.out_valid, 1'b0);
    cyc(1);

    // Counter clear on the main stage
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    #1 chk("clr_stall_cnt", stall_cnt, 16'd0);
    chk("clr_bubble_cnt", bubble_cnt, 16'd0);

    // Reset mid-stream, then reset together with flush and halt
    nxt = 48'h300;
    beat(1'b1); beat(1'b1); beat(1'b1);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1; bus.in_valid = 1'b0;
    #1 chk_reset_state("rst_mid");
    bus.in_valid = 1'b1; bus.in_data = 48'h400; bus.in_ctrl = ctrl_of(48'h400); bus.out_ready = 1'b0;
    cyc(1);
    rst = 1'b0; flush = 1'b1; halt_sys = 1'b1;
    cyc(1);
    rst = 1'b1; flush = 1'b0; halt_sys = 1'b0; bus.in_valid = 1'b0;
    #1 chk_reset_state("rst_flush_halt");

    // CNT_W=4 saturation and clear overriding increment
    c_stall = 1'b1;
    cyc(7);
    chk("c_stall_7", c_scnt, 4'd7);
    cyc(13);
    chk("c_stall_sat", c_scnt, 4'd15);
    c_clr = 1'b1;
    cyc(1);
    c_clr = 1'b0;
    #1 chk("c_clr_zero", c_scnt, 4'd0);
    cyc(1);
    chk("c_after_clr", c_scnt, 4'd1);
    c_stall = 1'b0;

    bus.out_ready = 1'b1;
    cyc(3);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register replacing the fixed-field, stall-only stage registers between CPU pipeline stages. It carries a generic data word plus a control word through one register slot, with a valid/ready handshake, an optional one-entry skid buffer, and a synchronous flush that inserts a bubble. It also keeps saturating performance counters for stall and bubble cycles. Instances sit between decode→ALU, ALU→memory and memory→writeback.

## Interface
Parameters:
- DATA_W, 48: payload width (ALU operands, R1 data, etc. concatenated by the instantiating stage).
- CTRL_W, 12: control width (memc, reg_wr, R0_en, alu_ctrl, instr bits).
- CTRL_NOP, 0: control value loaded on reset and flush; must encode no write and no memory access.
- SKID, 1: 1 adds a one-entry skid buffer; 0 gives a plain register slot.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- halt_sys  in  1  system halt; freezes the stage.
- stall  in  1  hazard stall; freezes the stage.
- flush  in  1  discard the contents of the stage and insert a bubble.
- cnt_clr  in  1  synchronous clear of both counters.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  registered payload.
- out_ctrl  out  CTRL_W  registered control.
- stall_cnt  out  CNT_W  cycles in which halt_sys or stall was high.
- bubble_cnt  out  CNT_W  unfrozen cycles with the main slot empty.

## Operation
- State:
  - main slot: vq, out_data, out_ctrl.
  - skid slot (SKID=1 only): sv, sdata, sctrl.
- frz = halt_sys | stall.
- Transfer rules:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
- Output and ready equations:
  - out_valid = vq & ~frz.
  - SKID=1: in_ready = rst & ~frz & ~sv. No combinational path from out_ready.
  - SKID=0: in_ready = rst & ~frz & (~vq | out_ready).
- Update priority, evaluated per edge:
  1. rst low: vq=0, sv=0, out_data=0, sdata=0, out_ctrl=CTRL_NOP, sctrl=CTRL_NOP, both counters=0.
  2. flush: vq=0, sv=0, out_ctrl=CTRL_NOP. out_data holds. Any beat accepted in the same cycle is dropped. Flush overrides frz.
  3. frz: all slot state holds. Both handshakes are blocked.
  4. Normal operation:
     - If the main slot drains (~vq | out_ready):
       - sv=1: the skid slot moves to main; sv=0. Any accept this cycle is impossible because in_ready is 0.
       - else if accept: the input moves to main; vq=1.
       - else: vq=0.
     - If the main slot is blocked (vq & ~out_ready) and accept: the input moves to skid; sv=1.
- Ordering: beats leave in acceptance order. No beat is lost or duplicated except by flush.
- Counters:
  - stall_cnt increments when frz=1.
  - bubble_cnt increments when vq=0 & frz=0 & flush=0.
  - Both saturate at 2^CNT_W−1.
  - cnt_clr zeroes both; it overrides an increment in the same cycle. Reset also zeroes both.
- out_ctrl is CTRL_NOP whenever vq=0 after a reset or flush. Downstream may rely on this for hazard logic.

## Timing
- Latency is 1 cycle from accept to out_valid when the stage is empty.
- Throughput is one beat per cycle with out_ready held high.
- SKID=1 absorbs exactly one beat when out_ready falls. in_ready falls the cycle after the skid slot fills.
- Effects of frz:
  - in_ready and out_valid drop in the same cycle frz rises.
  - Contents reappear unchanged the cycle frz falls.
- flush takes effect at the edge; the next cycle shows out_valid=0 and in_ready=1 (if not frozen).
- Releasing reset: in_ready=1 on the first cycle with rst high.

## Test plan
- Stream of data 1..8 with in_valid=1 and out_ready=1, SKID=1 → out_data 1..8 on consecutive cycles, 1-cycle latency, bubble_cnt stops increasing once streaming.
- Streaming, then drop out_ready for 3 cycles while in_valid=1 → exactly one extra beat held in skid, in_ready=0 for the following cycles, no loss or reordering after out_ready returns.
- stall high for 4 cycles with vq=1, data=0xABCD → out_valid=0 and in_ready=0 throughout, stall_cnt +4, out_data=0xABCD valid again the following cycle.
- flush with both slots full, asserted together with stall → next cycle vq=0, out_ctrl=CTRL_NOP, in_ready=1. Neither held beat is ever emitted.
- rst low mid-stream for 1 cycle → all outputs at reset values the next cycle, counters 0. rst low together with flush and halt_sys → same result.
- CNT_W=4, stall held for 20 cycles → stall_cnt saturates at 15. Pulsing cnt_clr → 0 the next cycle.
